// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        if_resp_err;

   logic        d_req_valid;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic        d_req_we;
   logic        d_req_ready;
   logic        d_resp_valid;
   logic [31:0] d_resp_data;
   logic        d_resp_err;

   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [31:0] mem_read_data;

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      output d_req_valid, d_req_addr, d_req_wdata, d_req_we,
      input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
      input  mem_address, mem_write_data, mem_write_enable,
      output mem_read_data
   );

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
      input  d_req_valid, d_req_addr, d_req_wdata, d_req_we,
      output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
      output mem_address, mem_write_data, mem_write_enable,
      input  mem_read_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto a single-port word memory
// Alternating priority on contention; every accepted request gets a one-cycle response slot.
module mem_arbiter #(
   parameter int WORDS = 64
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        resp_id_q;
   logic [31:0] resp_data_q;
   logic        resp_err_q;

   logic        grant_if, grant_d;
   logic        win_err;
   logic        if_resp_on, d_resp_on;

   function automatic logic addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(WORDS));
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_if || grant_d) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grants exist only in IDLE outside reset; the port not served last wins a tie.
   always_comb begin
      grant_if             = 1'b0;
      grant_d              = 1'b0;
      win_err              = 1'b0;
      bus.mem_address      = 32'h0;
      bus.mem_write_data   = 32'h0;
      bus.mem_write_enable = 1'b0;
      if (state_q == IDLE && !rst) begin
         grant_if = bus.if_req_valid && (!bus.d_req_valid || last_grant_q == GNT_D);
         grant_d  = bus.d_req_valid && (!bus.if_req_valid || last_grant_q == GNT_IF);
      end
      if (grant_d) begin
         win_err              = addr_err(bus.d_req_addr);
         bus.mem_address      = bus.d_req_addr;
         bus.mem_write_data   = bus.d_req_wdata;
         bus.mem_write_enable = bus.d_req_we && !win_err;
      end else if (grant_if) begin
         win_err         = addr_err(bus.if_req_addr);
         bus.mem_address = bus.if_req_addr;
      end
      bus.if_req_ready  = grant_if;
      bus.d_req_ready   = grant_d;

      if_resp_on        = (state_q == RESP) && (resp_id_q == GNT_IF);
      d_resp_on         = (state_q == RESP) && (resp_id_q == GNT_D);
      bus.if_resp_valid = if_resp_on;
      bus.if_resp_data  = if_resp_on ? resp_data_q : 32'h0;
      bus.if_resp_err   = if_resp_on && resp_err_q;
      bus.d_resp_valid  = d_resp_on;
      bus.d_resp_data   = d_resp_on ? resp_data_q : 32'h0;
      bus.d_resp_err    = d_resp_on && resp_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= GNT_D;
         resp_id_q    <= GNT_IF;
         resp_data_q  <= 32'h0;
         resp_err_q   <= 1'b0;
      end else if (grant_if || grant_d) begin
         last_grant_q <= grant_d;
         resp_id_q    <= grant_d;
         resp_err_q   <= win_err;
         resp_data_q  <= (win_err || (grant_d && bus.d_req_we)) ? 32'h0 : bus.mem_read_data;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter against a transaction model
module tb_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();
   mem_arbiter #(.WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [31:0] ram     [0:63];
   logic [31:0] mdl_mem [0:63];

   assign bus.mem_read_data = (bus.mem_address[31:8] == 24'h0) ? ram[bus.mem_address[7:2]] : 32'h0;
   always @(posedge clk) if (bus.mem_write_enable) ram[bus.mem_address[7:2]] <= bus.mem_write_data;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_err(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd256);
   endfunction

   // Transaction model: pending response slot, last served port, its own copy of memory.
   bit          m_resp   = 1'b0;
   bit          m_last_d = 1'b1;
   bit          m_id     = 1'b0;
   logic [31:0] m_data   = 32'h0;
   bit          m_err    = 1'b0;

   always @(negedge clk) begin
      bit wi, wd, e, ri, rd;
      logic [31:0] ea;
      wi = !m_resp && !rst && bus.if_req_valid && (!bus.d_req_valid || m_last_d);
      wd = !m_resp && !rst && bus.d_req_valid && (!bus.if_req_valid || !m_last_d);
      chk("if_req_ready", 32'(bus.if_req_ready), 32'(wi));
      chk("d_req_ready", 32'(bus.d_req_ready), 32'(wd));
      if (!rst && !m_resp) begin
         ea = wi ? bus.if_req_addr : (wd ? bus.d_req_addr : 32'h0);
         chk("mem_address", bus.mem_address, ea);
         chk("mem_write_data", bus.mem_write_data, wd ? bus.d_req_wdata : 32'h0);
      end
      chk("mem_write_enable", 32'(bus.mem_write_enable),
          32'(wd && bus.d_req_we && !is_err(bus.d_req_addr)));
      ri = m_resp && !m_id;
      rd = m_resp && m_id;
      chk("if_resp_valid", 32'(bus.if_resp_valid), 32'(ri));
      chk("if_resp_data", bus.if_resp_data, ri ? m_data : 32'h0);
      chk("if_resp_err", 32'(bus.if_resp_err), 32'(ri && m_err));
      chk("d_resp_valid", 32'(bus.d_resp_valid), 32'(rd));
      chk("d_resp_data", bus.d_resp_data, rd ? m_data : 32'h0);
      chk("d_resp_err", 32'(bus.d_resp_err), 32'(rd && m_err));

      if (rst) begin
         m_resp = 1'b0; m_last_d = 1'b1; m_data = 32'h0; m_err = 1'b0;
      end else if (m_resp) begin
         m_resp = 1'b0;
      end else if (wi || wd) begin
         ea       = wd ? bus.d_req_addr : bus.if_req_addr;
         e        = is_err(ea);
         m_resp   = 1'b1;
         m_id     = wd;
         m_last_d = wd;
         m_err    = e;
         m_data   = (e || (wd && bus.d_req_we)) ? 32'h0 : mdl_mem[ea / 4];
         if (wd && bus.d_req_we && !e) mdl_mem[ea / 4] = bus.d_req_wdata;
      end
   end

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return $urandom;
      if (r == 1) return ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
      if (r == 2) return ($urandom_range(0, 1) != 0) ? 32'd252 : 32'd256;
      return $urandom_range(0, 7) * 4;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit hs_if, hs_d;
      for (int i = 0; i < 64; i++) begin
         ram[i]     = $urandom;
         mdl_mem[i] = ram[i];
      end
      ram[2]     = 32'hDEADBEEF;
      mdl_mem[2] = 32'hDEADBEEF;
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
      bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h4;
      bus.d_req_wdata  = 32'h0; bus.d_req_we   = 1'b1;

      // Requests held while in reset must see no ready and no write.
      repeat (2) @(negedge clk);
      chk("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
      chk("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
      chk("rst_we", 32'(bus.mem_write_enable), 32'd0);
      chk("rst_if_resp_valid", 32'(bus.if_resp_valid), 32'd0);
      chk("rst_d_resp_valid", 32'(bus.d_resp_valid), 32'd0);
      next_cycle();
      rst = 1'b0; bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0;

      // Fetch of mem[2].
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
      @(negedge clk);
      chk("t034_ready", 32'(bus.if_req_ready), 32'd1);
      next_cycle(); bus.if_req_valid = 1'b0;
      @(negedge clk);
      chk("t034_resp_valid", 32'(bus.if_resp_valid), 32'd1);
      chk("t034_resp_data", bus.if_resp_data, 32'hDEADBEEF);
      chk("t034_resp_err", 32'(bus.if_resp_err), 32'd0);

      // Store then load back.
      next_cycle();
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h10; bus.d_req_wdata = 32'h12345678; bus.d_req_we = 1'b1;
      @(negedge clk);
      chk("t035_we", 32'(bus.mem_write_enable), 32'd1);
      chk("t035_wdata", bus.mem_write_data, 32'h12345678);
      next_cycle(); bus.d_req_valid = 1'b0;
      @(negedge clk);
      chk("t035_store_resp_data", bus.d_resp_data, 32'h0);
      next_cycle();
      bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0;
      @(negedge clk);
      chk("t035_load_ready", 32'(bus.d_req_ready), 32'd1);
      next_cycle(); bus.d_req_valid = 1'b0;
      @(negedge clk);
      chk("t035_load_data", bus.d_resp_data, 32'h12345678);

      // Continuous contention from reset alternates IF, D every other cycle.
      next_cycle(); rst = 1'b1;
      next_cycle(); rst = 1'b0;
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0;
      bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h4; bus.d_req_we = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("t036_if_ready_c%0d", c), 32'(bus.if_req_ready), 32'(c % 4 == 0));
         chk($sformatf("t036_d_ready_c%0d", c), 32'(bus.d_req_ready), 32'(c % 4 == 2));
         next_cycle();
      end
      bus.if_req_valid = 1'b0;

      // Misaligned and out-of-range stores.
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h13; bus.d_req_wdata = 32'hFFFF0000; bus.d_req_we = 1'b1;
      @(negedge clk);
      chk("t037a_we", 32'(bus.mem_write_enable), 32'd0);
      next_cycle(); bus.d_req_valid = 1'b0;
      @(negedge clk);
      chk("t037a_err", 32'(bus.d_resp_err), 32'd1);
      chk("t037a_data", bus.d_resp_data, 32'h0);
      next_cycle();
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h100;
      @(negedge clk);
      chk("t037b_we", 32'(bus.mem_write_enable), 32'd0);
      next_cycle(); bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0;
      @(negedge clk);
      chk("t037b_err", 32'(bus.d_resp_err), 32'd1);
      chk("t037b_data", bus.d_resp_data, 32'h0);

      // Reset during the response slot of a fetch.
      next_cycle();
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
      @(negedge clk);
      chk("t038_ready", 32'(bus.if_req_ready), 32'd1);
      next_cycle(); bus.if_req_valid = 1'b0; rst = 1'b1;
      next_cycle(); rst = 1'b0;
      bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h0;
      bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h4;
      @(negedge clk);
      chk("t038_resp_dropped", 32'(bus.if_resp_valid), 32'd0);
      chk("t038_if_wins", 32'(bus.if_req_ready), 32'd1);
      chk("t038_d_loses", 32'(bus.d_req_ready), 32'd0);
      next_cycle();
      bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;

      // Randomized traffic; requests are held until accepted.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         hs_if = bus.if_req_valid && bus.if_req_ready;
         hs_d  = bus.d_req_valid && bus.d_req_ready;
         next_cycle();
         rst = ($urandom_range(0, 99) == 0);
         if (!bus.if_req_valid || hs_if) begin
            bus.if_req_valid = ($urandom_range(0, 2) != 0);
            bus.if_req_addr  = rand_addr();
         end
         if (!bus.d_req_valid || hs_d) begin
            bus.d_req_valid = ($urandom_range(0, 2) != 0);
            bus.d_req_addr  = rand_addr();
            bus.d_req_wdata = $urandom;
            bus.d_req_we    = ($urandom_range(0, 1) != 0);
         end
      end
      rst = 1'b0; bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 64, number of 32-bit words in the shared memory; word index = addr[31:2].
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req_valid  input  1  instruction-fetch read request.
REQ-005 SHALL have port if_req_addr  input  32  fetch byte address.
REQ-006 SHALL have port if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_resp_valid  output  1  fetch response present.
REQ-008 SHALL have port if_resp_data  output  32  fetched word.
REQ-009 SHALL have port if_resp_err  output  1  fetch address misaligned or out of range.
REQ-010 SHALL have port d_req_valid  input  1  data load/store request.
REQ-011 SHALL have port d_req_addr  input  32  data byte address.
REQ-012 SHALL have port d_req_wdata  input  32  store data.
REQ-013 SHALL have port d_req_we  input  1  1 = store, 0 = load.
REQ-014 SHALL have port d_req_ready  output  1  data request accepted this cycle.
REQ-015 SHALL have port d_resp_valid  output  1  data response present.
REQ-016 SHALL have port d_resp_data  output  32  loaded word; 0 for stores and errors.
REQ-017 SHALL have port d_resp_err  output  1  data address misaligned or out of range.
REQ-018 SHALL have ports mem_address (output 32), mem_write_data (output 32), mem_write_enable (output 1), mem_read_data (input 32, combinational read of mem_address) to the single-port word memory.

Function
REQ-019 SHALL implement FSM with states IDLE and RESP; reset state IDLE.
REQ-020 In IDLE, one valid requester SHALL win; both valid -> winner is the port not granted last (last_grant register, reset value D, so IF wins first contention).
REQ-021 ready SHALL be asserted combinationally only in IDLE, only to the winner; handshake = valid && ready; loser's ready = 0.
REQ-022 Requesters SHALL hold valid/addr/wdata/we stable until ready; arbiter need not tolerate changes.
REQ-023 On the handshake cycle mem_address SHALL equal winner's addr; mem_write_data = d_req_wdata when D wins, else 0.
REQ-024 mem_write_enable SHALL be 1 only on a D handshake with d_req_we=1, addr[1:0]=0, addr[31:2] < WORDS, rst=0; otherwise 0.
REQ-025 Error condition: addr[1:0] != 0 or addr[31:2] >= WORDS; error requests SHALL not write and SHALL return data 0, err 1.
REQ-026 On handshake the arbiter SHALL register mem_read_data (loads/fetches, no error) or 0 (stores/errors), err flag, and winner id; update last_grant; go to RESP.
REQ-027 RESP SHALL last exactly one cycle: winner's resp_valid = 1 with registered data/err; then IDLE; latency handshake -> resp_valid = 1 cycle.
REQ-028 In RESP both ready outputs SHALL be 0; max throughput one request per 2 cycles.
REQ-029 Non-winner resp_valid SHALL be 0; resp_data/resp_err SHALL be 0 when resp_valid = 0.
REQ-030 In IDLE with no valid request, mem_address = 0, mem_write_data = 0, mem_write_enable = 0.

Reset
REQ-031 With rst=1 at a clock edge: state <= IDLE, last_grant <= D, registered data/err <= 0, both resp_valid <= 0.
REQ-032 While rst=1, both ready and mem_write_enable SHALL be 0 combinationally; no handshake occurs.
REQ-033 Reset asserted in RESP SHALL drop resp_valid the following cycle; the pending response is lost.

Verification
REQ-034 Reset then IF read addr 0x8 with mem[2]=0xDEADBEEF -> if_req_ready=1 cycle 0, if_resp_valid=1 data 0xDEADBEEF err 0 cycle 1.
REQ-035 D store addr 0x10 wdata 0x12345678 -> mem_write_enable=1 cycle 0; later D load 0x10 -> d_resp_data 0x12345678.
REQ-036 Both valid continuously from reset -> grants IF, D, IF, D on handshake cycles 0, 2, 4, 6; no back-to-back accepts.
REQ-037 D store addr 0x13 and D store addr 0x100 (WORDS=64) -> mem_write_enable=0, d_resp_err=1, d_resp_data=0.
REQ-038 rst=1 during RESP of IF read -> if_resp_valid=0 next cycle, state IDLE, next contention grants IF.
